// File: rtl/writeback_module.sv
// -----------------------------------------------------------------------------
// writeback_module
//
// Purpose:
//   Final stage of the pipeline. Holds one WB pipeline register, captured from
//   the MEM stage on each rising clk, and produces the register-file write port
//   combinationally from that register (one cycle of latency). It also counts
//   the instructions that retire.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst_n          asynchronous, active-low reset
//   in_valid       MEM stage presents a valid instruction
//   stall          hold the current WB contents
//   flush          discard the incoming instruction and load a bubble
//   opcode, funct  instruction[31:26] / instruction[5:0]
//   rt, rd         instruction[20:16] / instruction[15:11]
//   alu_result     ALU result (link address for jal)
//   mem_read_data  data-memory load result
//   reg_write      register-file write enable
//   write_reg      destination register number
//   write_data     data to write
//   wb_valid       WB register holds a valid instruction
//   retired_count  number of retired instructions (wraps)
// -----------------------------------------------------------------------------
module writeback_module (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_read_data,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        wb_valid,
  output logic [31:0] retired_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic        valid_q;
  logic        done_q;
  logic [5:0]  opcode_q;
  logic [5:0]  funct_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [31:0] alu_q;
  logic [31:0] mem_q;
  logic [31:0] retired_q;

  // The entry acts (writes and retires) only in its first valid cycle; done
  // marks a held entry that has already acted so a long stall cannot repeat it.
  logic retire;
  assign retire = valid_q & ~done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      opcode_q  <= '0;
      funct_q   <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      mem_q     <= '0;
      retired_q <= '0;
    end else begin
      if (retire) begin
        retired_q <= retired_q + 32'd1;
      end

      if (flush) begin
        // Bubble. A write already issued by the old entry stays issued.
        valid_q  <= 1'b0;
        done_q   <= 1'b0;
        opcode_q <= '0;
        funct_q  <= '0;
        rt_q     <= '0;
        rd_q     <= '0;
        alu_q    <= '0;
        mem_q    <= '0;
      end else if (stall) begin
        if (retire) begin
          done_q <= 1'b1;
        end
      end else begin
        valid_q  <= in_valid;
        done_q   <= 1'b0;
        opcode_q <= opcode;
        funct_q  <= funct;
        rt_q     <= rt;
        rd_q     <= rd;
        alu_q    <= alu_result;
        mem_q    <= mem_read_data;
      end
    end
  end

  logic write_capable;

  always_comb begin
    write_capable = 1'b0;
    write_reg     = rt_q;
    write_data    = alu_q;

    unique case (opcode_q)
      OP_RTYPE: begin
        write_capable = (funct_q != FN_JR);
        write_reg     = rd_q;
      end
      OP_JAL: begin
        write_capable = 1'b1;
        write_reg     = 5'd31;
      end
      OP_LW: begin
        write_capable = 1'b1;
        write_data    = mem_q;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        write_capable = 1'b1;
      end
      default: begin
        write_capable = 1'b0;
      end
    endcase
  end

  assign reg_write     = retire & write_capable & (write_reg != 5'd0);
  assign wb_valid      = valid_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_writeback_module.sv
module tb_writeback_module;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] mem_read_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        wb_valid;
  logic [31:0] retired_count;

  writeback_module dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .opcode        (opcode),
    .funct         (funct),
    .rt            (rt),
    .rd            (rd),
    .alu_result    (alu_result),
    .mem_read_data (mem_read_data),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .wb_valid      (wb_valid),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the instruction sitting in WB and whether it has acted.
  typedef struct {
    bit          valid;
    bit          acted;
    bit [5:0]    op;
    bit [5:0]    fn;
    bit [4:0]    rt;
    bit [4:0]    rd;
    bit [31:0]   alu;
    bit [31:0]   mem;
  } entry_t;

  entry_t      m;
  bit [31:0]   m_count;
  int          write_events;

  function automatic bit op_writes(bit [5:0] op, bit [5:0] fn);
    if (op == 6'h00) return fn != 6'h08;
    return op inside {6'h23, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F, 6'h03};
  endfunction

  function automatic bit [4:0] dest_of(entry_t e);
    if (e.op == 6'h00) return e.rd;
    if (e.op == 6'h03) return 5'd31;
    return e.rt;
  endfunction

  function automatic bit [31:0] data_of(entry_t e);
    return (e.op == 6'h23) ? e.mem : e.alu;
  endfunction

  function automatic bit exp_write(entry_t e);
    return e.valid && !e.acted && op_writes(e.op, e.fn) && dest_of(e) != 5'd0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".reg_write"},     {31'd0, reg_write},  {31'd0, exp_write(m)});
    check({tag, ".write_reg"},     {27'd0, write_reg},  {27'd0, dest_of(m)});
    check({tag, ".write_data"},    write_data,          data_of(m));
    check({tag, ".wb_valid"},      {31'd0, wb_valid},   {31'd0, m.valid});
    check({tag, ".retired_count"}, retired_count,       m_count);
  endtask

  task automatic model_clear();
    m       = '{default: '0};
    m_count = '0;
  endtask

  task automatic model_edge();
    if (m.valid && !m.acted) m_count = m_count + 32'd1;
    if (flush) begin
      m = '{default: '0};
    end else if (stall) begin
      if (m.valid) m.acted = 1'b1;
    end else begin
      m = '{valid: in_valid, acted: 1'b0, op: opcode, fn: funct, rt: rt, rd: rd,
            alu: alu_result, mem: mem_read_data};
    end
  endtask

  task automatic drive(bit iv, bit st, bit fl, bit [5:0] op, bit [5:0] fn,
                       bit [4:0] rt_v, bit [4:0] rd_v, bit [31:0] alu, bit [31:0] mem);
    in_valid      = iv;
    stall         = st;
    flush         = fl;
    opcode        = op;
    funct         = fn;
    rt            = rt_v;
    rd            = rd_v;
    alu_result    = alu;
    mem_read_data = mem;
  endtask

  task automatic cycle(string tag);
    @(posedge clk);
    model_edge();
    #1;
    if (reg_write) write_events++;
    check_all(tag);
  endtask

  bit [5:0] op_pool [14] = '{6'h00, 6'h23, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
                             6'h0A, 6'h0F, 6'h03, 6'h2B, 6'h04, 6'h02, 6'h05};
  bit [5:0] fn_pool [4]  = '{6'h20, 6'h08, 6'h21, 6'h2A};

  initial begin
    bit [31:0] cnt0;
    model_clear();
    rst_n = 1'b0;
    drive(0, 0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0);
    #2;
    check_all("reset");
    #10 rst_n = 1'b1;

    // R-type add
    drive(1, 0, 0, 6'h00, 6'h20, 5'd9, 5'd5, 32'h12, 32'h99);
    cycle("add");
    check("add.rw", {31'd0, reg_write}, 32'd1);
    check("add.wreg", {27'd0, write_reg}, 32'd5);
    check("add.wdata", write_data, 32'h12);

    // lw
    drive(1, 0, 0, 6'h23, 6'h00, 5'd7, 5'd2, 32'h40, 32'hDEADBEEF);
    cycle("lw");
    check("lw.wreg", {27'd0, write_reg}, 32'd7);
    check("lw.wdata", write_data, 32'hDEADBEEF);
    check("lw.count", retired_count, 32'd1);

    // addi held under a 4-cycle stall: one write, one retire
    drive(1, 0, 0, 6'h08, 6'h00, 5'd3, 5'd0, 32'h77, 32'h0);
    cycle("addi");
    cnt0 = retired_count;
    write_events = 1;
    check("addi.rw", {31'd0, reg_write}, 32'd1);
    drive(1, 1, 0, 6'h00, 6'h20, 5'd4, 5'd4, 32'h1, 32'h1);
    for (int i = 0; i < 4; i++) cycle("addi_stall");
    check("stall.writes", write_events, 32'd1);
    check("stall.retires", retired_count - cnt0, 32'd1);

    // Non-writing and $0 cases: each still retires
    drive(1, 0, 0, 6'h2B, 6'h00, 5'd6, 5'd0, 32'h5, 32'h0);
    cycle("sw");
    check("sw.rw", {31'd0, reg_write}, 32'd0);
    drive(1, 0, 0, 6'h00, 6'h08, 5'd0, 5'd31, 32'h5, 32'h0);
    cycle("jr");
    check("jr.rw", {31'd0, reg_write}, 32'd0);
    drive(1, 0, 0, 6'h08, 6'h00, 5'd0, 5'd0, 32'h5, 32'h0);
    cycle("addi0");
    check("addi0.rw", {31'd0, reg_write}, 32'd0);
    drive(0, 0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 32'h0, 32'h0);
    cycle("bubble");
    check("nonwr.count", retired_count, cnt0 + 32'd4);

    // jal
    drive(1, 0, 0, 6'h03, 6'h00, 5'd2, 5'd3, 32'h1000, 32'h0);
    cycle("jal");
    check("jal.wreg", {27'd0, write_reg}, 32'd31);

    // flush together with stall
    drive(1, 1, 1, 6'h08, 6'h00, 5'd3, 5'd0, 32'h1, 32'h0);
    cycle("flush_stall");
    check("flush.wbv", {31'd0, wb_valid}, 32'd0);

    // Counter wrap
    drive(1, 0, 0, 6'h0D, 6'h00, 5'd8, 5'd0, 32'hF0, 32'h0);
    cycle("ori");
    #1 force dut.retired_q = 32'hFFFFFFFF;
    #1 release dut.retired_q;
    m_count = 32'hFFFFFFFF;
    check("wrap.pre", retired_count, 32'hFFFFFFFF);
    drive(0, 0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 32'h0, 32'h0);
    cycle("wrap");
    check("wrap.post", retired_count, 32'h0);

    // Reset during a held lw
    drive(1, 0, 0, 6'h23, 6'h00, 5'd7, 5'd0, 32'h40, 32'hCAFEF00D);
    cycle("lw2");
    drive(1, 1, 0, 6'h00, 6'h20, 5'd1, 5'd1, 32'h0, 32'h0);
    cycle("lw2_stall");
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    check_all("midrst");
    check("midrst.count", retired_count, 32'd0);
    #1 rst_n = 1'b1;
    drive(1, 0, 0, 6'h09, 6'h00, 5'd12, 5'd0, 32'hABC, 32'h0);
    cycle("post_rst");
    check("post_rst.rw", {31'd0, reg_write}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit [5:0] op;
      bit [5:0] fn;
      op = op_pool[$urandom_range(0, 13)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 3)];
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
            op, fn, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom),
            5'($urandom_range(0, 7) == 0 ? 0 : $urandom), $urandom, $urandom);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback_module.md
WRITEBACK_MODULE -- requirements
Module: writeback_module

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  MEM stage presents a valid instruction this cycle.
REQ-004 stall  input  1  hold the current WB contents (no capture).
REQ-005 flush  input  1  discard the incoming instruction and load a bubble.
REQ-006 opcode  input  6  instruction[31:26] of the MEM-stage instruction.
REQ-007 funct  input  6  instruction[5:0] of the MEM-stage instruction.
REQ-008 rt  input  5  instruction[20:16] of the MEM-stage instruction.
REQ-009 rd  input  5  instruction[15:11] of the MEM-stage instruction.
REQ-010 alu_result  input  32  ALU result (link address for jal).
REQ-011 mem_read_data  input  32  data-memory load result.
REQ-012 reg_write  output  1  register-file write enable (drives the decode-stage reg_write input).
REQ-013 write_reg  output  5  destination register number.
REQ-014 write_data  output  32  data to write.
REQ-015 wb_valid  output  1  the WB register holds a valid instruction.
REQ-016 retired_count  output  32  count of instructions retired.

Function
REQ-017 The block SHALL hold a single WB pipeline register (valid, opcode, funct, rt, rd, alu_result, mem_read_data, done flag) and update it only on rising clk.
REQ-018 Capture priority SHALL be flush > stall > normal: flush=1 loads valid=0; otherwise stall=1 holds all fields; otherwise the register loads the inputs with valid=in_valid and done=0.
REQ-019 While stall=1 and the register is held, done SHALL be set to 1 at the end of the first cycle the held entry is valid.
REQ-020 Write-capable opcodes SHALL be: 0x00 (R-type, except funct 0x08 jr), 0x23 lw, 0x08 addi, 0x09 addiu, 0x0C andi, 0x0D ori, 0x0E xori, 0x0A slti, 0x0F lui, and 0x03 jal; every other opcode SHALL not write.
REQ-021 write_reg SHALL be rd for opcode 0x00, 5'd31 for jal, and rt for all other opcodes.
REQ-022 write_data SHALL be mem_read_data for lw and alu_result for all other opcodes.
REQ-023 reg_write SHALL be 1 only when valid=1, done=0, the opcode is write-capable, and write_reg is not 0.
REQ-024 reg_write, write_reg and write_data SHALL be combinational from the WB register, giving one-cycle latency from MEM inputs to the register-file write.
REQ-025 wb_valid SHALL equal the stored valid bit.
REQ-026 retired_count SHALL increment by 1 on each rising edge where valid=1 and done=0, including non-writing instructions and writes to $0.
REQ-027 retired_count SHALL wrap from 0xFFFFFFFF to 0x00000000.
REQ-028 A held entry SHALL produce exactly one write and one retire, regardless of how long stall stays asserted.
REQ-029 flush asserted together with stall SHALL replace the held entry with a bubble; if that entry already wrote in an earlier cycle, the write SHALL not be undone.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously force valid=0, done=0, all stored fields to 0, and retired_count=0.
REQ-031 During reset the outputs SHALL read reg_write=0, write_reg=0, write_data=0 and wb_valid=0.
REQ-032 Reset asserted mid-stall SHALL discard the held instruction; after rst_n rises, the first capture SHALL occur at the next rising clk.

Verification
REQ-033 R-type add: opcode 0x00, funct 0x20, rd=5, alu_result=0x12 -> one cycle later reg_write=1, write_reg=5, write_data=0x12, retired_count +1.
REQ-034 lw: opcode 0x23, rt=7, mem_read_data=0xDEADBEEF, alu_result=0x40 -> write_reg=7, write_data=0xDEADBEEF.
REQ-035 Stalled addi: opcode 0x08, rt=3, stall held 4 cycles -> reg_write=1 in exactly 1 cycle, retired_count +1 only once.
REQ-036 Non-writing and $0 cases: sw (0x2B), jr (funct 0x08), and addi with rt=0 -> reg_write=0 in each case, each still retires.
REQ-037 Flush and wrap: flush=1 with stall=1 gives wb_valid=0 next cycle; with retired_count forced to 0xFFFFFFFF, one retire gives 0x00000000.
REQ-038 Reset mid-stall: rst_n pulsed low during a held lw -> all outputs 0 immediately, retired_count=0.
